// File: rtl/rv_hazard_sb.sv
// rv_hazard_sb: hazard and forwarding controller for a 5-stage RV32 pipeline.
// Covers E-stage forwarding, load-use bubbles (LU_STALL deep), and a register
// scoreboard for a single multi-cycle unit (MDU). An FSM arbitrates the MDU
// write-back onto the shared W write port.
// Optional feature: define RV_HAZ_STATS_EN to add the stall/flush/wb-bubble
// statistics counters.
module rv_hazard_sb #(
  parameter int NREG     = 32,
  parameter int RA_W     = 5,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            D_Valid,
  input  logic [RA_W-1:0] D_Rs1,
  input  logic [RA_W-1:0] D_Rs2,
  input  logic            D_Rs1Use,
  input  logic            D_Rs2Use,
  input  logic [RA_W-1:0] D_Rd,
  input  logic            D_RegWrite,
  input  logic            D_MultiCycle,
  input  logic [RA_W-1:0] E_Rs1,
  input  logic [RA_W-1:0] E_Rs2,
  input  logic [RA_W-1:0] E_Rd,
  input  logic            E_IsLoad,
  input  logic            E_RegWrite,
  input  logic            E_PCSrc,
  input  logic [RA_W-1:0] M_Rd,
  input  logic [RA_W-1:0] W_Rd,
  input  logic            M_RegWrite,
  input  logic            W_RegWrite,
  input  logic            mdu_done,
  output logic            F_Stall,
  output logic            D_Stall,
  output logic            D_Flush,
  output logic            E_Flush,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
`ifdef RV_HAZ_STATS_EN
  output logic [CNT_W-1:0] stat_stall,
  output logic [CNT_W-1:0] stat_flush,
  output logic [CNT_W-1:0] stat_wbbub,
`endif
  output logic            mdu_issue,
  output logic            mdu_wb_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state;
  logic [NREG-1:0] busy;
  logic [RA_W-1:0] mdu_rd;
  logic [1:0]      lu_cnt;

  logic            lu_hazard;
  logic            raw_hazard;
  logic            waw_hazard;
  logic            struct_hazard;
  logic            wb_wait;
  logic            stall_any;

  // Hazard sources; x0 is excluded everywhere since it is never written
  always_comb begin
    lu_hazard = E_IsLoad && E_RegWrite && (E_Rd != '0) &&
                ((D_Rs1Use && (D_Rs1 == E_Rd)) || (D_Rs2Use && (D_Rs2 == E_Rd)));
    raw_hazard = (D_Rs1Use && (D_Rs1 != '0) && busy[D_Rs1]) ||
                 (D_Rs2Use && (D_Rs2 != '0) && busy[D_Rs2]);
    waw_hazard = D_RegWrite && (D_Rd != '0) && busy[D_Rd];
    struct_hazard = D_MultiCycle && (state != IDLE);
    wb_wait = (state == WB) && W_RegWrite;
    stall_any = lu_hazard || (lu_cnt != 2'd0) || raw_hazard || waw_hazard ||
                struct_hazard || wb_wait;
  end

  // Stall/flush resolution: a taken branch in E is older than anything in D, so it wins
  always_comb begin
    F_Stall = 1'b0;
    D_Stall = 1'b0;
    D_Flush = 1'b0;
    E_Flush = 1'b0;
    if (rst_n) begin
      if (E_PCSrc) begin
        D_Flush = 1'b1;
        E_Flush = 1'b1;
      end else if (stall_any) begin
        F_Stall = 1'b1;
        D_Stall = 1'b1;
        E_Flush = 1'b1;
      end
    end
  end

  // E-stage forward selects: M result is newer than W result so it takes priority
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      if (M_RegWrite && (M_Rd != '0) && (M_Rd == E_Rs1))
        ForwardAE = 2'b10;
      else if (W_RegWrite && (W_Rd != '0) && (W_Rd == E_Rs1))
        ForwardAE = 2'b01;
      if (M_RegWrite && (M_Rd != '0) && (M_Rd == E_Rs2))
        ForwardBE = 2'b10;
      else if (W_RegWrite && (W_Rd != '0) && (W_Rd == E_Rs2))
        ForwardBE = 2'b01;
    end
  end

  // MDU issue and write-port grant; the grant takes the first free W slot
  always_comb begin
    mdu_issue    = rst_n && D_Valid && D_MultiCycle && !D_Stall && !D_Flush;
    mdu_wb_grant = rst_n && (state == WB) && !W_RegWrite;
  end

  // Load-use bubble counter: reload on a new hazard, count down to 0, cleared by redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lu_cnt <= 2'd0;
    else if (E_PCSrc)
      lu_cnt <= 2'd0;
    else if (lu_hazard)
      lu_cnt <= 2'(LU_STALL - 1);
    else if (lu_cnt != 2'd0)
      lu_cnt <= lu_cnt - 2'd1;
  end

  // MDU sequencing FSM; remembers the destination so the grant can clear its busy bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mdu_rd <= '0;
    end else begin
      case (state)
        IDLE: if (mdu_issue) begin
          state  <= BUSY;
          mdu_rd <= D_Rd;
        end
        BUSY: if (mdu_done) state <= WB;
        WB:   if (mdu_wb_grant) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Scoreboard: busy from issue until the end of the grant cycle (issue and grant never coincide)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (mdu_wb_grant)
        busy[mdu_rd] <= 1'b0;
      if (mdu_issue && (D_Rd != '0))
        busy[D_Rd] <= 1'b1;
    end
  end

`ifdef RV_HAZ_STATS_EN
  // Statistics counters, free-running and wrapping on overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall <= '0;
      stat_flush <= '0;
      stat_wbbub <= '0;
    end else begin
      if (F_Stall) stat_stall <= stat_stall + 1'b1;
      if (E_PCSrc) stat_flush <= stat_flush + 1'b1;
      if (wb_wait) stat_wbbub <= stat_wbbub + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_hazard_sb.sv
// Scoreboard bench for rv_hazard_sb (LU_STALL=2): the stimulus process queues the
// hand-computed response for each cycle, the monitor pops and compares at negedge.
module tb_rv_hazard_sb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       D_Valid, D_Rs1Use, D_Rs2Use, D_RegWrite, D_MultiCycle;
  logic [4:0] D_Rs1, D_Rs2, D_Rd, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd;
  logic       E_IsLoad, E_RegWrite, E_PCSrc, M_RegWrite, W_RegWrite, mdu_done;
  logic       F_Stall, D_Stall, D_Flush, E_Flush, mdu_issue, mdu_wb_grant;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef RV_HAZ_STATS_EN
  logic [31:0] stat_stall, stat_flush, stat_wbbub;
`endif

  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rv_hazard_sb #(.NREG(32), .RA_W(5), .LU_STALL(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_Valid(D_Valid), .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .D_Rs1Use(D_Rs1Use),
    .D_Rs2Use(D_Rs2Use), .D_Rd(D_Rd), .D_RegWrite(D_RegWrite),
    .D_MultiCycle(D_MultiCycle), .E_Rs1(E_Rs1), .E_Rs2(E_Rs2), .E_Rd(E_Rd),
    .E_IsLoad(E_IsLoad), .E_RegWrite(E_RegWrite), .E_PCSrc(E_PCSrc),
    .M_Rd(M_Rd), .W_Rd(W_Rd), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
    .mdu_done(mdu_done), .F_Stall(F_Stall), .D_Stall(D_Stall),
    .D_Flush(D_Flush), .E_Flush(E_Flush), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
`ifdef RV_HAZ_STATS_EN
    .stat_stall(stat_stall), .stat_flush(stat_flush), .stat_wbbub(stat_wbbub),
`endif
    .mdu_issue(mdu_issue), .mdu_wb_grant(mdu_wb_grant)
  );

  // Packs {F_Stall, D_Stall, D_Flush, E_Flush, ForwardAE, ForwardBE, mdu_issue, mdu_wb_grant}
  function automatic logic [9:0] pk(input logic st, input logic df, input logic ef,
                                    input logic [1:0] fa, input logic [1:0] fb,
                                    input logic iss, input logic gr);
    return {st, st, df, ef, fa, fb, iss, gr};
  endfunction

  task automatic clearInputs();
    D_Valid = 0; D_Rs1Use = 0; D_Rs2Use = 0; D_RegWrite = 0; D_MultiCycle = 0;
    D_Rs1 = 0; D_Rs2 = 0; D_Rd = 0; E_Rs1 = 0; E_Rs2 = 0; E_Rd = 0;
    M_Rd = 0; W_Rd = 0; E_IsLoad = 0; E_RegWrite = 0; E_PCSrc = 0;
    M_RegWrite = 0; W_RegWrite = 0; mdu_done = 0;
  endtask

  // Queue the expected response for the inputs just driven, then advance one cycle
  task automatic applyStimulus(input string name, input logic [9:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [9:0] act;
    act = {F_Stall, D_Stall, D_Flush, E_Flush, ForwardAE, ForwardBE, mdu_issue, mdu_wb_grant};
    total++;
    if (act !== e.v) begin
      bad++;
      $display("[TB] FAIL %s actual=%b required=%b (Fs Ds Df Ef AE BE iss gnt)", e.name, act, e.v);
    end
  endtask

  // Monitor: compares whenever a response is pending
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    rst_n = 0;
    @(posedge clk); #1;
    applyStimulus("reset", pk(0,0,0,2'b00,2'b00,0,0));
    rst_n = 1;

    // Forwarding
    M_RegWrite = 1; M_Rd = 5; W_RegWrite = 1; W_Rd = 5; E_Rs1 = 5;
    applyStimulus("fwd_m_prio", pk(0,0,0,2'b10,2'b00,0,0));
    M_RegWrite = 0; E_Rs2 = 5;
    applyStimulus("fwd_w", pk(0,0,0,2'b01,2'b01,0,0));
    M_RegWrite = 1; M_Rd = 0; W_Rd = 0; E_Rs1 = 0; E_Rs2 = 0;
    applyStimulus("fwd_x0", pk(0,0,0,2'b00,2'b00,0,0));
    M_Rd = 9; E_Rs2 = 9; W_Rd = 3; E_Rs1 = 3;
    applyStimulus("fwd_mixed", pk(0,0,0,2'b01,2'b10,0,0));
    clearInputs();

    // Load-use, two bubbles
    E_IsLoad = 1; E_RegWrite = 1; E_Rd = 6; D_Valid = 1; D_Rs1 = 6; D_Rs1Use = 1;
    applyStimulus("lu_c1", pk(1,0,1,2'b00,2'b00,0,0));
    E_IsLoad = 0; E_RegWrite = 0; E_Rd = 0; M_RegWrite = 1; M_Rd = 6;
    applyStimulus("lu_c2", pk(1,0,1,2'b00,2'b00,0,0));
    M_RegWrite = 0; M_Rd = 0; W_RegWrite = 1; W_Rd = 6; E_Rs1 = 6; D_Rs1 = 1;
    applyStimulus("lu_release", pk(0,0,0,2'b01,2'b00,0,0));
    clearInputs();
    E_IsLoad = 1; E_RegWrite = 1; E_Rd = 6; D_Valid = 1; D_Rs2 = 6; D_Rs2Use = 0;
    applyStimulus("lu_unused_src", pk(0,0,0,2'b00,2'b00,0,0));
    E_Rd = 0; D_Rs2 = 0; D_Rs2Use = 1;
    applyStimulus("lu_x0", pk(0,0,0,2'b00,2'b00,0,0));
    clearInputs();

    // Branch redirect overrides a pending load-use and blocks MDU issue
    E_IsLoad = 1; E_RegWrite = 1; E_Rd = 8; D_Valid = 1; D_Rs1 = 8; D_Rs1Use = 1;
    applyStimulus("pc_lu_set", pk(1,0,1,2'b00,2'b00,0,0));
    clearInputs();
    E_PCSrc = 1; D_Valid = 1; D_MultiCycle = 1; D_RegWrite = 1; D_Rd = 9;
    applyStimulus("pc_flush", pk(0,1,1,2'b00,2'b00,0,0));
    clearInputs();
    D_Valid = 1; D_Rs1 = 2; D_Rs1Use = 1;
    applyStimulus("pc_lucnt_clr", pk(0,0,0,2'b00,2'b00,0,0));

    // MDU RAW: mul x7 then a reader of x7
    clearInputs();
    D_Valid = 1; D_MultiCycle = 1; D_RegWrite = 1; D_Rd = 7;
    applyStimulus("mdu1_issue", pk(0,0,0,2'b00,2'b00,1,0));
    D_MultiCycle = 0; D_Rd = 10; D_Rs1 = 7; D_Rs1Use = 1;
    applyStimulus("mdu1_raw_a", pk(1,0,1,2'b00,2'b00,0,0));
    applyStimulus("mdu1_raw_b", pk(1,0,1,2'b00,2'b00,0,0));
    mdu_done = 1;
    applyStimulus("mdu1_done", pk(1,0,1,2'b00,2'b00,0,0));
    mdu_done = 0;
    applyStimulus("mdu1_grant", pk(1,0,1,2'b00,2'b00,0,1));
    applyStimulus("mdu1_release", pk(0,0,0,2'b00,2'b00,0,0));

    // MDU WAW, structural, W-port contention
    clearInputs();
    D_Valid = 1; D_MultiCycle = 1; D_RegWrite = 1; D_Rd = 11;
    applyStimulus("mdu2_issue", pk(0,0,0,2'b00,2'b00,1,0));
    D_MultiCycle = 0;
    applyStimulus("mdu2_waw", pk(1,0,1,2'b00,2'b00,0,0));
    D_MultiCycle = 1; D_Rd = 13;
    applyStimulus("mdu2_struct", pk(1,0,1,2'b00,2'b00,0,0));
    D_MultiCycle = 0; D_Rd = 14; mdu_done = 1;
    applyStimulus("mdu2_done", pk(0,0,0,2'b00,2'b00,0,0));
    mdu_done = 0; W_RegWrite = 1; W_Rd = 3;
    applyStimulus("mdu2_wbwait1", pk(1,0,1,2'b00,2'b00,0,0));
    applyStimulus("mdu2_wbwait2", pk(1,0,1,2'b00,2'b00,0,0));
    W_RegWrite = 0;
    applyStimulus("mdu2_grant", pk(0,0,0,2'b00,2'b00,0,1));
    applyStimulus("mdu2_idle", pk(0,0,0,2'b00,2'b00,0,0));
    mdu_done = 1;
    applyStimulus("done_in_idle", pk(0,0,0,2'b00,2'b00,0,0));
    mdu_done = 0;
    applyStimulus("done_in_idle_nogrant", pk(0,0,0,2'b00,2'b00,0,0));

    // Reset while BUSY abandons the op
    clearInputs();
    D_Valid = 1; D_MultiCycle = 1; D_RegWrite = 1; D_Rd = 12;
    applyStimulus("mdu3_issue", pk(0,0,0,2'b00,2'b00,1,0));
    clearInputs();
    rst_n = 0;
    applyStimulus("mdu3_reset", pk(0,0,0,2'b00,2'b00,0,0));
    rst_n = 1; mdu_done = 1;
    applyStimulus("mdu3_done_ign", pk(0,0,0,2'b00,2'b00,0,0));
    mdu_done = 0;
    applyStimulus("mdu3_nogrant", pk(0,0,0,2'b00,2'b00,0,0));
    D_Valid = 1; D_Rs1 = 12; D_Rs1Use = 1;
    applyStimulus("mdu3_busy_clr", pk(0,0,0,2'b00,2'b00,0,0));

    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
